sevenseg_capture: RTL

SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

---
 rtl/sevenseg_capture.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sevenseg_capture.sv
// Recovers digit codes by watching a multiplexed, active-low 7-segment display bus.
// Latency: STABLE_CYCLES+1 clocks from an input change to the output update.
// Backpressure: none; the display is sampled continuously and captures are never stalled.
module sevenseg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [7:0] seg,
    input  logic       clr_err,
    output logic [4:0] d0,
    output logic [4:0] d1,
    output logic [4:0] d2,
    output logic [4:0] d3,
    output logic [3:0] dp,
    output logic [3:0] digit_valid,
    output logic       frame_done,
    output logic       multi_an_err,
    output logic       bad_glyph_err
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
    localparam logic [4:0] CODE_BLANK = 5'h1D;
    localparam logic [4:0] CODE_BAD   = 5'h1F;

    logic [3:0] an_q, an_prev;
    logic [7:0] seg_q, seg_prev;
    logic [7:0] dwell_cnt, dwell_nxt;
    logic [4:0] digit_q [4];

    logic       sample_diff;
    logic       capture;
    logic [3:0] sel;
    logic       one_hot;
    logic       multi;
    logic [4:0] code;
    logic       glyph_bad;
    logic [3:0] valid_post;

    function automatic logic [4:0] decode(input logic [6:0] g, input logic dp_on);
        logic [4:0] c;
        case (g)
            7'h3F: c = 5'h00;
            7'h06: c = 5'h01;
            7'h5B: c = 5'h02;
            7'h4F: c = 5'h03;
            7'h66: c = 5'h04;
            7'h6D: c = 5'h05;
            7'h7D: c = 5'h06;
            7'h07: c = 5'h07;
            7'h7F: c = 5'h08;
            7'h6F: c = 5'h09;
            7'h77: c = 5'h0A;
            7'h7C: c = 5'h0B;
            7'h39: c = 5'h0C;
            7'h5E: c = 5'h0D;
            7'h79: c = 5'h0E;
            7'h71: c = 5'h0F;
            7'h01: c = 5'h10;
            7'h02: c = 5'h11;
            7'h04: c = 5'h12;
            7'h08: c = 5'h13;
            7'h10: c = 5'h14;
            7'h20: c = 5'h15;
            7'h40: c = 5'h16;
            7'h76: c = 5'h18;
            7'h38: c = 5'h19;
            7'h31: c = 5'h1A;
            7'h30: c = 5'h1B;
            7'h50: c = 5'h1C;
            7'h00: c = dp_on ? 5'h17 : CODE_BLANK;
            default: c = CODE_BAD;
        endcase
        return c;
    endfunction

    always_comb begin
        sample_diff = ({an_q, seg_q} != {an_prev, seg_prev});
        if (sample_diff)
            dwell_nxt = 8'd1;
        else if (dwell_cnt == STABLE)
            dwell_nxt = dwell_cnt;
        else
            dwell_nxt = dwell_cnt + 8'd1;
        // Fires only on the edge the counter arrives at STABLE, so a held input never recaptures.
        capture    = (dwell_nxt == STABLE) && (dwell_cnt != STABLE);
        sel        = ~an_q;
        one_hot    = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
        multi      = (sel != 4'b0000) && !one_hot;
        code       = decode(~seg_q[6:0], ~seg_q[7]);
        glyph_bad  = (code == CODE_BAD);
        valid_post = digit_valid | sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q          <= 4'hF;
            seg_q         <= 8'hFF;
            an_prev       <= 4'hF;
            seg_prev      <= 8'hFF;
            dwell_cnt     <= 8'd0;
            for (int i = 0; i < 4; i++) digit_q[i] <= CODE_BLANK;
            dp            <= 4'b0000;
            digit_valid   <= 4'b0000;
            frame_done    <= 1'b0;
            multi_an_err  <= 1'b0;
            bad_glyph_err <= 1'b0;
        end else begin
            an_q       <= an;
            seg_q      <= seg;
            an_prev    <= an_q;
            seg_prev   <= seg_q;
            dwell_cnt  <= dwell_nxt;
            frame_done <= 1'b0;

            if (capture && one_hot) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) begin
                        digit_q[i] <= code;
                        dp[i]      <= ~seg_q[7];
                    end
                end
                // Completing the set pulses frame_done and rearms for the next frame.
                if (valid_post == 4'b1111) begin
                    frame_done  <= 1'b1;
                    digit_valid <= 4'b0000;
                end else begin
                    digit_valid <= valid_post;
                end
            end

            multi_an_err  <= (capture && multi) || (multi_an_err && !clr_err);
            bad_glyph_err <= (capture && one_hot && glyph_bad) || (bad_glyph_err && !clr_err);
        end
    end

    assign d0 = digit_q[0];
    assign d1 = digit_q[1];
    assign d2 = digit_q[2];
    assign d3 = digit_q[3];

endmodule
